// File: rtl/mul_pkg.sv
// Shared widths and state encoding for the shift-add multiplier-accumulator.
package mul_pkg;
  localparam int WA = 32;
  localparam int WB = 16;
  localparam int PW = WA + WB;
  localparam int CW = $clog2(WB);

  typedef enum logic [1:0] {IDLE, MUL, ADD} mul_state_t;
endpackage

// File: rtl/mul_add_seq_if.sv
// Operand/result bundle between a requester (master) and mul_add_seq (slave).
interface mul_add_seq_if;
  import mul_pkg::*;

  logic [WA-1:0] a;
  logic [WB-1:0] b;
  logic [WB-1:0] c;
  logic          start;
  logic [PW-1:0] p;
  logic          ready;
  logic          busy;
  logic [CW-1:0] count;

  modport master (output a, b, c, start, input p, ready, busy, count);
  modport slave  (input a, b, c, start, output p, ready, busy, count);
endinterface

// File: rtl/mul_step.sv
// One radix-2 shift-add iteration: conditionally add a into hi, then shift {hi,lo} right.
module mul_step
  import mul_pkg::*;
(
  input  logic [WA:0]   hi,
  input  logic [WB-1:0] lo,
  input  logic [WA-1:0] a,
  output logic [WA:0]   hi_next,
  output logic [WB-1:0] lo_next
);
  logic [WA:0] sum;

  always_comb begin
    sum     = lo[0] ? (hi + {1'b0, a}) : hi;
    // carry out of the add lands in the top bit of the shifted product
    hi_next = {1'b0, sum[WA:1]};
    lo_next = {sum[0], lo[WB-1:1]};
  end
endmodule

// File: rtl/mul_add_seq.sv
// Sequential p = a*b (+ c when MUL_ADDEND_EN is defined), one multiplier bit per clock.
// Start restarts from any state; p only updates on completion.
module mul_add_seq
  import mul_pkg::*;
(
  input  logic         clk,
  input  logic         clrn,
  mul_add_seq_if.slave bus
);
  mul_state_t    state_reg, state_next;
  logic [WA-1:0] a_reg, a_next;
  logic [WA:0]   hi_reg, hi_next;
  logic [WB-1:0] lo_reg, lo_next;
  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] p_reg, p_next;
  logic          ready_reg, ready_next;
  logic          busy_reg, busy_next;
  logic [WA:0]   hi_step;
  logic [WB-1:0] lo_step;

`ifdef MUL_ADDEND_EN
  logic [WB-1:0] c_reg, c_next;
`else
  logic unused_c;
  assign unused_c = ^bus.c;
`endif

  mul_step u_step (
    .hi      (hi_reg),
    .lo      (lo_reg),
    .a       (a_reg),
    .hi_next (hi_step),
    .lo_next (lo_step)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg <= IDLE;
      count_reg <= '0;
      p_reg     <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      p_reg     <= p_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
    end
  end

  // Operand and partial-product registers need no reset: they are reloaded on every start.
  always_ff @(posedge clk) begin
    a_reg  <= a_next;
    hi_reg <= hi_next;
    lo_reg <= lo_next;
`ifdef MUL_ADDEND_EN
    c_reg  <= c_next;
`endif
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    count_next = count_reg;
    p_next     = p_reg;
    ready_next = ready_reg;
    busy_next  = busy_reg;
`ifdef MUL_ADDEND_EN
    c_next     = c_reg;
`endif

    if (bus.start) begin
      a_next     = bus.a;
      hi_next    = '0;
      lo_next    = bus.b;
`ifdef MUL_ADDEND_EN
      c_next     = bus.c;
`endif
      count_next = '0;
      busy_next  = 1'b1;
      ready_next = 1'b0;
      state_next = MUL;
    end else begin
      case (state_reg)
        MUL: begin
          hi_next = hi_step;
          lo_next = lo_step;
          if (count_reg == CW'(WB - 1)) begin
            count_next = '0;
`ifdef MUL_ADDEND_EN
            state_next = ADD;
`else
            p_next     = {hi_step[WA-1:0], lo_step};
            busy_next  = 1'b0;
            ready_next = 1'b1;
            state_next = IDLE;
`endif
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
`ifdef MUL_ADDEND_EN
        ADD: begin
          p_next     = {hi_reg[WA-1:0], lo_reg} + PW'(c_reg);
          busy_next  = 1'b0;
          ready_next = 1'b1;
          state_next = IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.p     = p_reg;
  assign bus.ready = ready_reg;
  assign bus.busy  = busy_reg;
  assign bus.count = count_reg;
endmodule

// File: tb/tb_mul_add_seq.sv
// Scoreboard bench for mul_add_seq: stimulus pushes expected results, a negedge monitor checks them.
module tb_mul_add_seq;
  import mul_pkg::*;

`ifdef MUL_ADDEND_EN
  localparam int LAT = WB + 1;
`else
  localparam int LAT = WB;
`endif

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  mul_add_seq_if bus ();

  mul_add_seq dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  typedef struct {
    logic [PW-1:0] p;
    int            k;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   passed = 0;
  int   total  = 0;
  logic prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] sel(input logic [PW-1:0] plain, input logic [PW-1:0] add);
`ifdef MUL_ADDEND_EN
    return add;
`else
    return plain;
`endif
  endfunction

  // Monitor: a rising ready marks a completed result.
  always @(negedge clk) begin
    check("ready_busy_exclusive", {63'b0, bus.ready & bus.busy}, 64'd0);
    if (bus.ready && !prev_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: p=0x%0h with no result pending", bus.p);
      end else begin
        mon_e = sb.pop_front();
        $display("done: p=0x%0h expected 0x%0h latency %0d", bus.p, mon_e.p, cyc - mon_e.k);
        check("result_p", bus.p, mon_e.p);
        check("latency", cyc - mon_e.k, LAT);
        check("count_at_done", bus.count, 0);
      end
    end
    prev_ready <= bus.ready;
  end

  task automatic start_op(input logic [WA-1:0] a, input logic [WB-1:0] b, input logic [WB-1:0] c,
                          input logic [PW-1:0] exp_plain, input logic [PW-1:0] exp_add);
    exp_t e;
    @(negedge clk);
    if (bus.busy && sb.size() > 0) e = sb.pop_back();
    bus.a = a;
    bus.b = b;
    bus.c = c;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e.k = cyc;
    e.p = sel(exp_plain, exp_add);
    sb.push_back(e);
    $display("start: a=0x%0h b=0x%0h c=0x%0h expect 0x%0h", a, b, c, e.p);
    check("busy_after_start", bus.busy, 1);
    check("ready_after_start", bus.ready, 0);
    check("count_after_start", bus.count, 0);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0) return;
    end
    total++;
    $display("FAIL %s: timeout with %0d results outstanding", name, sb.size());
    sb.delete();
  endtask

  task automatic wait_count(input int n);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.count == CW'(n)) return;
    end
    total++;
    $display("FAIL wait_count: count never reached %0d", n);
  endtask

  initial begin
    bus.a = '0;
    bus.b = '0;
    bus.c = '0;
    bus.start = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_p", bus.p, 0);
    check("reset_ready", bus.ready, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_count", bus.count, 0);
    clrn = 1'b1;
    repeat (2) @(negedge clk);

    // 7*3 (+2)
    start_op(32'd7, 16'd3, 16'd2, 48'h000000000015, 48'h000000000017);
    wait_done("small");
    repeat (3) @(negedge clk);
    check("idle_hold_p", bus.p, sel(48'h15, 48'h17));
    check("idle_hold_ready", bus.ready, 1);
    check("idle_hold_busy", bus.busy, 0);

    // b=0: full-length run, count sequence, p holds previous result meanwhile
    start_op(32'h12345678, 16'h0000, 16'h00AB, 48'h000000000000, 48'h0000000000AB);
    for (int i = 1; i <= WB; i++) begin
      @(posedge clk);
      #1;
      check("count_seq", bus.count, i % WB);
      if (i < WB) check("p_no_partial", bus.p, sel(48'h15, 48'h17));
    end
    wait_done("b_zero");

    // Maximum operands
    start_op(32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 48'hFFFEFFFF0001, 48'hFFFF00000000);
    wait_done("max");

    // Divider round trip: 123456 = 246*500 + 456
    start_op(32'h000000F6, 16'h01F4, 16'h01C8, 48'h00000001E078, 48'h00000001E240);
    wait_done("round_trip");

    // Single high bits: 2^31 * 2^15 (+0x1234)
    start_op(32'h80000000, 16'h8000, 16'h1234, 48'h400000000000, 48'h400000001234);
    wait_done("msb");

    // Restart while busy: first run must never complete
    start_op(32'd5, 16'd5, 16'd0, 48'd25, 48'd25);
    wait_count(8);
    start_op(32'd2, 16'd3, 16'd0, 48'd6, 48'd6);
    wait_done("restart");

    // Asynchronous reset mid-operation
    start_op(32'd7, 16'd3, 16'd2, 48'h15, 48'h17);
    wait_count(10);
    clrn = 1'b0;
    #1;
    sb.delete();
    check("midreset_p", bus.p, 0);
    check("midreset_busy", bus.busy, 0);
    check("midreset_ready", bus.ready, 0);
    check("midreset_count", bus.count, 0);
    @(negedge clk);
    clrn = 1'b1;
    repeat (25) @(negedge clk);
    check("post_reset_idle_busy", bus.busy, 0);
    check("post_reset_idle_ready", bus.ready, 0);
    check("post_reset_idle_p", bus.p, 0);

    // Recovery after reset
    start_op(32'd9, 16'd9, 16'd4, 48'd81, 48'd85);
    wait_done("recover");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
